wb_arbiter: RTL

Parametrised writeback arbiter between execution/memory/FPU result sources and the GPR write ports. Each source gets a small result FIFO, so results that lose arbitration are held rather than dropped. Up to NPORT register-file writes are granted per cycle, in round-robin order. Sits between the exec/mem/FPU stages and the register file, and replaces hard-wired priority chains.

---
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding NPORT GPR write ports in round-robin order.
// Latency 1 cycle from src_valid to wr_*. Sources get no backpressure; src_almost_full warns issue logic, and a push into a full FIFO sets sticky overflow.
module wb_arbiter #(
    parameter int NSRC           = 8,
    parameter int NPORT          = 2,
    parameter int XLEN           = 32,
    parameter int RADDR          = 5,
    parameter int DEPTH          = 4,
    parameter int ZERO_HARDWIRED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   interlock,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*RADDR-1:0]  src_rd,
    input  logic [NSRC*XLEN-1:0]   src_data,
    output logic [NSRC-1:0]        src_almost_full,
    output logic [NPORT-1:0]       wr_en,
    output logic [NPORT*RADDR-1:0] wr_addr,
    output logic [NPORT*XLEN-1:0]  wr_data,
    output logic                   pending,
    output logic                   overflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam int SW  = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int SW1 = SW + 1;
    localparam int EW  = RADDR + XLEN;

    logic [NSRC-1:0][DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [NSRC-1:0][AW-1:0]            rp_q, rp_d, wp_q, wp_d;
    logic [NSRC-1:0][AW:0]              cnt_q, cnt_d;
    logic [SW-1:0]                      rr_q, rr_d;
    logic [NPORT-1:0]                   wr_en_q, wr_en_d;
    logic [NPORT-1:0][RADDR-1:0]        wr_addr_q, wr_addr_d;
    logic [NPORT-1:0][XLEN-1:0]         wr_data_q, wr_data_d;
    logic                               overflow_q, overflow_d;

    logic [NSRC-1:0]          in_vld, has_head, cand_vld, gnt, pop, push, full;
    logic [NSRC-1:0][EW-1:0]  in_ent, cand_ent;
    logic [SW1-1:0]           idx_w;
    logic [SW-1:0]            idx;
    logic                     conflict;
    int                       ngnt;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            in_ent[i]   = {src_rd[i*RADDR +: RADDR], src_data[i*XLEN +: XLEN]};
            in_vld[i]   = src_valid[i] &&
                          !((ZERO_HARDWIRED != 0) && (src_rd[i*RADDR +: RADDR] == '0));
            has_head[i] = (cnt_q[i] != '0);
            // An empty FIFO lets the incoming entry bypass, except during interlock.
            cand_vld[i] = has_head[i] || (in_vld[i] && !interlock);
            cand_ent[i] = has_head[i] ? mem_q[i][rp_q[i]] : in_ent[i];
        end
    end

    always_comb begin
        gnt       = '0;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_d      = rr_q;
        ngnt      = 0;
        idx_w     = '0;
        idx       = '0;
        conflict  = 1'b0;
        if (!interlock) begin
            for (int k = 0; k < NSRC; k++) begin
                idx_w = {1'b0, rr_q} + SW1'(k);
                if (idx_w >= SW1'(NSRC)) idx_w = idx_w - SW1'(NSRC);
                idx = idx_w[SW-1:0];
                if (cand_vld[idx] && (ngnt < NPORT)) begin
                    conflict = 1'b0;
                    for (int p = 0; p < NPORT; p++) begin
                        if ((p < ngnt) && (wr_addr_d[p] == cand_ent[idx][EW-1 -: RADDR]))
                            conflict = 1'b1;
                    end
                    if (!conflict) begin
                        gnt[idx] = 1'b1;
                        for (int p = 0; p < NPORT; p++) begin
                            if (p == ngnt) begin
                                wr_en_d[p]   = 1'b1;
                                wr_addr_d[p] = cand_ent[idx][EW-1 -: RADDR];
                                wr_data_d[p] = cand_ent[idx][XLEN-1:0];
                            end
                        end
                        ngnt = ngnt + 1;
                        rr_d = (idx == SW'(NSRC-1)) ? '0 : idx + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        mem_d      = mem_q;
        rp_d       = rp_q;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        for (int i = 0; i < NSRC; i++) begin
            pop[i]  = gnt[i] && has_head[i];
            push[i] = in_vld[i] && !(gnt[i] && !has_head[i]);
            full[i] = (cnt_q[i] == AW1'(DEPTH));
            if (pop[i]) rp_d[i] = rp_q[i] + 1'b1;
            if (push[i] && full[i] && !pop[i]) begin
                overflow_d = 1'b1;
            end else if (push[i]) begin
                mem_d[i][wp_q[i]] = in_ent[i];
                wp_d[i]           = wp_q[i] + 1'b1;
            end
            if (push[i] && !full[i] && !pop[i])      cnt_d[i] = cnt_q[i] + 1'b1;
            else if (pop[i] && !push[i])             cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q       <= '0;
            wp_q       <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; validity is carried entirely by the counts.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++)
            src_almost_full[i] = (cnt_q[i] >= AW1'(DEPTH-1));
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign overflow = overflow_q;
    assign pending  = (|has_head) || (|wr_en_q);
endmodule
